// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALU opcodes, FSM states and
// an index-width helper.
package alu_arb_pkg;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_XOR    = 3'b100;
  localparam logic [2:0] ALU_OP_MAX = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of a requester index; never less than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_rr_grant.sv
// Combinational round-robin grant: first valid requester searching upward from
// last_grant+1 with wrap-around.
module alu_rr_grant
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             any_req
);

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    // NOTE: every variable gets a default before the search so no latch is inferred.
    found     = 1'b0;
    cand      = '0;
    grant     = '0;
    grant_idx = '0;
    any_req   = |req_valid;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (any_req) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sequencer time-sharing one external ALU among N_REQ requesters.
// Optional macro ALU_SHARE_ARB_OPCHK_EN adds rsp_err and short-circuits illegal ops.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [3*N_REQ-1:0]  req_op,
  input  logic [DW*N_REQ-1:0] req_a,
  input  logic [DW*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [DW-1:0]       rsp_result,
  output logic                rsp_zero,
  output logic [2:0]          alu_ctrl,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  input  logic [DW-1:0]       alu_out,
  input  logic                alu_zero
`ifdef ALU_SHARE_ARB_OPCHK_EN
  ,
  output logic                rsp_err
`endif
);

  localparam int IW = idx_w(N_REQ);

  state_t         state, state_d;
  logic [IW-1:0]  last_grant, cur_idx, grant_idx;
  logic [N_REQ-1:0] grant;
  logic           any_req, accept;

  logic [2:0]     op_v [N_REQ];
  logic [DW-1:0]  a_v  [N_REQ];
  logic [DW-1:0]  b_v  [N_REQ];
  logic [2:0]     sel_op;
  logic [DW-1:0]  sel_a, sel_b;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign op_v[i] = req_op[3*i +: 3];
    assign a_v[i]  = req_a[DW*i +: DW];
    assign b_v[i]  = req_b[DW*i +: DW];
  end

  assign sel_op = op_v[grant_idx];
  assign sel_a  = a_v[grant_idx];
  assign sel_b  = b_v[grant_idx];

  alu_rr_grant #(.N_REQ(N_REQ), .IW(IW)) u_grant (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign req_ready = (state == IDLE) ? grant : '0;

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[cur_idx] = 1'b1;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (any_req) begin
        accept  = 1'b1;
        state_d = EXEC;
`ifdef ALU_SHARE_ARB_OPCHK_EN
        if (sel_op > ALU_OP_MAX) state_d = RESP;
`endif
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready[cur_idx]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Datapath registers are reset as well, so every output reads 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(N_REQ - 1);
      cur_idx    <= '0;
      alu_ctrl   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
`ifdef ALU_SHARE_ARB_OPCHK_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        last_grant <= grant_idx;
        cur_idx    <= grant_idx;
`ifdef ALU_SHARE_ARB_OPCHK_EN
        if (sel_op > ALU_OP_MAX) begin
          rsp_result <= '0;
          rsp_zero   <= 1'b0;
          rsp_err    <= 1'b1;
        end else begin
          alu_ctrl <= sel_op;
          alu_a    <= sel_a;
          alu_b    <= sel_b;
          rsp_err  <= 1'b0;
        end
`else
        alu_ctrl <= sel_op;
        alu_a    <= sel_a;
        alu_b    <= sel_b;
`endif
      end
      if (state == EXEC) begin
        rsp_result <= alu_out;
        rsp_zero   <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_alu_share_arb;
  import alu_arb_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;

  logic              clk, rst_n;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3*N-1:0]    req_op;
  logic [DW*N-1:0]   req_a, req_b;
  logic [DW-1:0]     rsp_result, alu_a, alu_b, alu_out;
  logic              rsp_zero, alu_zero;
  logic [2:0]        alu_ctrl;
`ifdef ALU_SHARE_ARB_OPCHK_EN
  logic              rsp_err;
`endif

  alu_share_arb #(.N_REQ(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero)
`ifdef ALU_SHARE_ARB_OPCHK_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [2:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    case (o)
      ALU_ADD: return x + y;
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_XOR: return x ^ y;
      default: return '0;
    endcase
  endfunction

  // External shared ALU.
  assign alu_out  = alu_f(alu_ctrl, alu_a, alu_b);
  assign alu_zero = (alu_out == '0);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side stimulus
  logic [N-1:0]  v, rr;
  logic [2:0]    op [N];
  logic [DW-1:0] a  [N];
  logic [DW-1:0] b  [N];
  int            acc_idx;

  // Reference model: one transaction in flight, cycles remaining before response.
  bit            m_busy;
  int            m_cnt, m_hold, m_last;
  logic [DW-1:0] m_res;
  bit            m_zero, m_err;
  logic [2:0]    m_ctrl;
  logic [DW-1:0] m_a, m_b;

  task automatic model_reset();
    m_busy = 0; m_cnt = 0; m_hold = 0; m_last = N - 1;
    m_res = '0; m_zero = 0; m_err = 0;
    m_ctrl = '0; m_a = '0; m_b = '0;
  endtask

  function automatic int winner(input logic [N-1:0] vv);
    for (int k = 1; k <= N; k++)
      if (vv[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  // One clock cycle: drive at negedge, check 1 time unit later, advance model.
  task automatic step();
    int w;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_op[3*i +: 3]  = op[i];
      req_a[DW*i +: DW] = a[i];
      req_b[DW*i +: DW] = b[i];
    end
    #1;
    acc_idx = -1;
    check("alu_ctrl", alu_ctrl, m_ctrl);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    if (!m_busy) begin
      check("rsp_valid_idle", rsp_valid, 0);
      w = winner(v);
      check("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
      if (w >= 0) begin
        acc_idx = w;
        m_busy  = 1;
        m_hold  = w;
        m_last  = w;
`ifdef ALU_SHARE_ARB_OPCHK_EN
        if (op[w] > 3'b100) begin
          m_cnt = 0; m_res = '0; m_zero = 0; m_err = 1;
        end else begin
          m_cnt = 1; m_res = alu_f(op[w], a[w], b[w]); m_zero = (m_res == '0); m_err = 0;
          m_ctrl = op[w]; m_a = a[w]; m_b = b[w];
        end
`else
        m_cnt = 1; m_res = alu_f(op[w], a[w], b[w]); m_zero = (m_res == '0); m_err = 0;
        m_ctrl = op[w]; m_a = a[w]; m_b = b[w];
`endif
      end
    end else if (m_cnt > 0) begin
      check("rsp_valid_exec", rsp_valid, 0);
      check("req_ready_exec", req_ready, 0);
      m_cnt--;
    end else begin
      check("rsp_valid", rsp_valid, 1 << m_hold);
      check("req_ready_resp", req_ready, 0);
      check("rsp_result", rsp_result, m_res);
      check("rsp_zero", rsp_zero, m_zero);
`ifdef ALU_SHARE_ARB_OPCHK_EN
      check("rsp_err", rsp_err, m_err);
`endif
      if (rr[m_hold]) m_busy = 0;
    end
  endtask

  task automatic drain(input int n);
    v  = '0;
    rr = '1;
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_result"}, rsp_result, 0);
    check({tag, "_rsp_zero"}, rsp_zero, 0);
    check({tag, "_alu_ctrl"}, alu_ctrl, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
`ifdef ALU_SHARE_ARB_OPCHK_EN
    check({tag, "_rsp_err"}, rsp_err, 0);
`endif
  endtask

  int grants[$];
  int t_acc, t_rsp;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    v = '0; rr = '1;
    for (int i = 0; i < N; i++) begin op[i] = '0; a[i] = '0; b[i] = '0; end
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Single add on requester 0; measure accept-to-response distance.
    v = 2'b01; op[0] = ALU_ADD; a[0] = 5; b[0] = 7; rr = '1;
    step();
    check("single_grant", acc_idx, 0);
    v = '0;
    t_acc = 0; t_rsp = -1;
    for (int c = 1; c <= 5 && t_rsp < 0; c++) begin
      step();
      if (rsp_valid != '0) begin
        t_rsp = c;
        check("single_result", rsp_result, 12);
        check("single_zero", rsp_zero, 0);
      end
    end
    check("single_latency", t_rsp, 2);
    drain(2);

    // Zero flag from requester 1.
    v = 2'b10; op[1] = ALU_SUB; a[1] = 32'h10; b[1] = 32'h10;
    step();
    check("zero_grant", acc_idx, 1);
    drain(3);

    // Fairness: both requesters continuously valid with xor operations.
    grants.delete();
    v = '1; rr = '1;
    for (int i = 0; i < N; i++) begin op[i] = ALU_XOR; a[i] = 32'h1000 + i; b[i] = 32'h00F0 << i; end
    for (int s = 0; s < 40 && grants.size() < 6; s++) begin
      step();
      if (acc_idx >= 0) begin
        grants.push_back(acc_idx);
        a[acc_idx] = $urandom;
        b[acc_idx] = $urandom;
      end
    end
    check("fair_count", grants.size(), 6);
    foreach (grants[i]) check("fair_grant", grants[i], i % 2);
    drain(3);

    // Backpressure: response held while requester 1 waits.
    v = 2'b11; rr = '0;
    op[0] = ALU_AND; a[0] = 32'hF0F0_1234; b[0] = 32'hFF00_FF0F;
    op[1] = ALU_OR;  a[1] = 32'h0000_0101; b[1] = 32'h1010_0000;
    step();
    check("bp_grant", acc_idx, 0);
    v[0] = 1'b0;
    repeat (6) step();
    check("bp_hold_valid", rsp_valid, 2'b01);
    rr = 2'b01;
    for (int s = 0; s < 6 && v[1]; s++) begin
      step();
      if (acc_idx == 1) v[1] = 1'b0;
    end
    check("bp_second_grant", v[1], 0);
    drain(3);

    // Illegal opcode: forwarded (default) or short-circuited with rsp_err.
    v = 2'b01; op[0] = 3'b110; a[0] = 32'hDEAD; b[0] = 32'hBEEF; rr = '1;
    step();
    check("illegal_grant", acc_idx, 0);
    v = '0;
    t_rsp = -1;
    for (int c = 1; c <= 5 && t_rsp < 0; c++) begin
      step();
      if (rsp_valid != '0) begin
        t_rsp = c;
        check("illegal_result", rsp_result, 0);
      end
    end
`ifdef ALU_SHARE_ARB_OPCHK_EN
    check("illegal_latency", t_rsp, 1);
`else
    check("illegal_latency", t_rsp, 2);
`endif
    drain(2);

    // Reset during EXEC: all outputs clear immediately, requester 0 wins afterwards.
    v = 2'b10; op[1] = ALU_ADD; a[1] = 32'h1; b[1] = 32'h2; rr = '1;
    step();
    v = '0;
    step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    v = 2'b11; op[0] = ALU_SUB; a[0] = 9; b[0] = 4; op[1] = ALU_ADD; a[1] = 1; b[1] = 1;
    step();
    check("post_reset_grant", acc_idx, 0);
    v[0] = 1'b0;
    for (int s = 0; s < 6 && v[1]; s++) begin
      step();
      if (acc_idx == 1) v[1] = 1'b0;
    end
    drain(3);

    // Random traffic with random backpressure.
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i]  = 1'b1;
          op[i] = ($urandom_range(0, 9) > 7) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
          a[i]  = $urandom;
          b[i]  = ($urandom_range(0, 3) == 0) ? a[i] : $urandom;
        end
      end
      for (int i = 0; i < N; i++) rr[i] = ($urandom_range(0, 2) != 0);
      step();
      if (acc_idx >= 0) v[acc_idx] = 1'b0;
    end
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
